// File: rtl/video_timing_if.sv
// Raster timing bundle between the video timing generator and its neighbours.
// The master side is the generator: it takes vreset/wide and drives the raster pins.
interface video_timing_if;
  logic        vreset;
  logic        wide;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] x;
  logic [10:0] y;
  logic        frame_start;
  logic        locked;

  modport master (
    input  vreset, wide,
    output hs, vs, de, x, y, frame_start, locked
  );

  modport slave (
    output vreset, wide,
    input  hs, vs, de, x, y, frame_start, locked
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster generator with normal/wide line formats, vreset snapping
// onto pixel (0,0) and a frame-count based lock indicator.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE_W  = 768,
  parameter int H_FP_W      = 16,
  parameter int H_SYNC_W    = 96,
  parameter int H_BP_W      = 144,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vt
);

  localparam logic [11:0] HA_N     = 12'(H_ACTIVE);
  localparam logic [11:0] HS_ON_N  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF_N = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HLAST_N  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HA_W     = 12'(H_ACTIVE_W);
  localparam logic [11:0] HS_ON_W  = 12'(H_ACTIVE_W + H_FP_W);
  localparam logic [11:0] HS_OFF_W = 12'(H_ACTIVE_W + H_FP_W + H_SYNC_W);
  localparam logic [11:0] HLAST_W  = 12'(H_ACTIVE_W + H_FP_W + H_SYNC_W + H_BP_W - 1);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VLAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [3:0]  LOCK_LAST = 4'(LOCK_FRAMES - 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [11:0] hc_r;
  logic [10:0] vc_r;
  logic        wide_q_r;
  logic [0:0]  state_r;
  logic [0:0]  state_nxt_s;
  logic [3:0]  frame_cnt_r;
  logic [3:0]  frame_cnt_nxt_s;

  logic [11:0] ha_s;
  logic [11:0] hs_on_s;
  logic [11:0] hs_off_s;
  logic [11:0] hlast_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        wide_load_s;
  logic        wide_chg_s;
  logic        misalign_s;

  logic        hs_r;
  logic        vs_r;
  logic        de_r;
  logic        fs_r;
  logic        locked_r;
  logic [11:0] x_r;
  logic [10:0] y_r;

  // Horizontal geometry follows the format latched at the start of the current line.
  always_comb begin
    if (wide_q_r) begin
      ha_s     = HA_W;
      hs_on_s  = HS_ON_W;
      hs_off_s = HS_OFF_W;
      hlast_s  = HLAST_W;
    end else begin
      ha_s     = HA_N;
      hs_on_s  = HS_ON_N;
      hs_off_s = HS_OFF_N;
      hlast_s  = HLAST_N;
    end
  end

  // An aligned vreset is one landing exactly where the raster would wrap to (0,0) anyway.
  assign h_wrap_s    = (hc_r == hlast_s);
  assign v_wrap_s    = h_wrap_s && (vc_r == VLAST);
  assign wide_load_s = h_wrap_s || vt.vreset;
  assign wide_chg_s  = wide_load_s && (vt.wide != wide_q_r);
  assign misalign_s  = vt.vreset && !v_wrap_s;

  // Raster counters and line-format latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_r     <= 12'd0;
      vc_r     <= 11'd0;
      wide_q_r <= 1'b0;
    end else begin
      if (wide_load_s) begin
        wide_q_r <= vt.wide;
      end
      if (vt.vreset) begin
        hc_r <= 12'd0;
        vc_r <= 11'd0;
      end else if (h_wrap_s) begin
        hc_r <= 12'd0;
        vc_r <= v_wrap_s ? 11'd0 : vc_r + 11'd1;
      end else begin
        hc_r <= hc_r + 12'd1;
      end
    end
  end

  // Lock tracking: any correction or format change restarts the clean-frame count.
  always_comb begin
    state_nxt_s     = state_r;
    frame_cnt_nxt_s = frame_cnt_r;
    if (wide_chg_s || misalign_s) begin
      state_nxt_s     = ST_UNLOCKED;
      frame_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ST_UNLOCKED: begin
          if (v_wrap_s) begin
            if (frame_cnt_r >= LOCK_LAST) begin
              state_nxt_s     = ST_LOCKED;
              frame_cnt_nxt_s = 4'd0;
            end else begin
              frame_cnt_nxt_s = frame_cnt_r + 4'd1;
            end
          end else begin
            frame_cnt_nxt_s = frame_cnt_r;
          end
        end
        ST_LOCKED: begin
          state_nxt_s     = ST_LOCKED;
          frame_cnt_nxt_s = 4'd0;
        end
        default: begin
          state_nxt_s     = ST_UNLOCKED;
          frame_cnt_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_UNLOCKED;
      frame_cnt_r <= 4'd0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKED);
    end
  end

  // Pin registers: decode the counter values of the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r <= ~HS_POL;
      vs_r <= ~VS_POL;
      de_r <= 1'b0;
      fs_r <= 1'b0;
      x_r  <= 12'd0;
      y_r  <= 11'd0;
    end else begin
      hs_r <= ((hc_r >= hs_on_s) && (hc_r < hs_off_s)) ? HS_POL : ~HS_POL;
      vs_r <= ((vc_r >= VS_ON) && (vc_r < VS_OFF)) ? VS_POL : ~VS_POL;
      de_r <= (hc_r < ha_s) && (vc_r < VA);
      fs_r <= (hc_r == 12'd0) && (vc_r == 11'd0);
      x_r  <= hc_r;
      y_r  <= vc_r;
    end
  end

  assign vt.hs          = hs_r;
  assign vt.vs          = vs_r;
  assign vt.de          = de_r;
  assign vt.x           = x_r;
  assign vt.y           = y_r;
  assign vt.frame_start = fs_r;
  assign vt.locked      = locked_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a shrunken raster: stimulus queues
// expected pin values per cycle, a negedge monitor pops and compares them.
module tb_video_timing_gen;
  localparam int HA   = 16;
  localparam int HFP  = 2;
  localparam int HSY  = 3;
  localparam int HBP  = 4;
  localparam int HT   = HA + HFP + HSY + HBP;       // 25
  localparam int HAW  = 20;
  localparam int HFPW = 2;
  localparam int HSYW = 3;
  localparam int HBPW = 5;
  localparam int HTW  = HAW + HFPW + HSYW + HBPW;   // 30
  localparam int VA   = 8;
  localparam int VFP  = 2;
  localparam int VSY  = 2;
  localparam int VBP  = 3;
  localparam int VT   = VA + VFP + VSY + VBP;       // 15
  localparam int FN   = HT * VT;                    // 375
  localparam int FW   = HTW * VT;                   // 450

  typedef struct {
    int c;
    int sel;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_c = 0;
  exp_t sbq[$];
  string sel_name [0:6] = '{"de", "hs", "vs", "x", "y", "frame_start", "locked"};

  video_timing_if vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .H_ACTIVE_W(HAW), .H_FP_W(HFPW), .H_SYNC_W(HSYW), .H_BP_W(HBPW),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vt(vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pin(input int sel);
    case (sel)
      0: return int'(vif.de);
      1: return int'(vif.hs);
      2: return int'(vif.vs);
      3: return int'(vif.x);
      4: return int'(vif.y);
      5: return int'(vif.frame_start);
      6: return int'(vif.locked);
      default: return -1;
    endcase
  endfunction

  // Monitor: compare every queued expectation due this cycle; flag any that slipped past.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].c <= cyc) begin
        checks++;
        if (sbq[i].c < cyc) begin
          errors++;
          $display("FAIL %s cyc=%0d never sampled (now %0d)", sel_name[sbq[i].sel], sbq[i].c, cyc);
        end else if (pin(sbq[i].sel) != sbq[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d exp=%0d", sel_name[sbq[i].sel], cyc,
                   pin(sbq[i].sel), sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic expect_pin(input int c, input int sel, input int val);
    exp_t e;
    e.c = c;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
    if (c > last_c) last_c = c;
  endtask

  // All pins for one line; pixel x of line y appears on the pins at cycle c0+x.
  task automatic push_line(input int c0, input int y, input bit w);
    int ha, hs0, hs1, ht;
    ha  = w ? HAW : HA;
    hs0 = ha + (w ? HFPW : HFP);
    hs1 = hs0 + (w ? HSYW : HSY);
    ht  = w ? HTW : HT;
    for (int x = 0; x < ht; x++) begin
      expect_pin(c0 + x, 0, (x < ha && y < VA) ? 1 : 0);
      expect_pin(c0 + x, 1, (x >= hs0 && x < hs1) ? 0 : 1);
      expect_pin(c0 + x, 2, (y >= VA + VFP && y < VA + VFP + VSY) ? 0 : 1);
      expect_pin(c0 + x, 3, x);
      expect_pin(c0 + x, 4, y);
      expect_pin(c0 + x, 5, (x == 0 && y == 0) ? 1 : 0);
    end
  endtask

  task automatic push_frame(input int c0, input bit w);
    for (int y = 0; y < VT; y++) push_line(c0 + y * (w ? HTW : HT), y, w);
  endtask

  task automatic push_reset_pins(input int c);
    expect_pin(c, 0, 0);
    expect_pin(c, 1, 1);
    expect_pin(c, 2, 1);
    expect_pin(c, 3, 0);
    expect_pin(c, 4, 0);
    expect_pin(c, 5, 0);
    expect_pin(c, 6, 0);
  endtask

  task automatic push_origin(input int c);
    expect_pin(c, 0, 1);
    expect_pin(c, 3, 0);
    expect_pin(c, 4, 0);
    expect_pin(c, 5, 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pixel k after base b is in the counters at negedge cyc=b+k and on the pins at b+1+k.
  initial begin
    int b, e, e5, b2, b3, c2, f0;
    vif.vreset = 1'b0;
    vif.wide   = 1'b0;

    // Reset state, then two normal frames with lock after the second.
    @(negedge clk);
    push_reset_pins(cyc + 1);
    @(negedge clk);
    reset = 1'b0;
    b = cyc;
    push_frame(b + 1, 1'b0);
    push_frame(b + 1 + FN, 1'b0);
    expect_pin(b + 1, 6, 0);
    expect_pin(b + 1 + 2 * FN - 2, 6, 0);
    expect_pin(b + 1 + 2 * FN - 1, 6, 1);
    wait_cyc(b + 2 * FN + 1);

    // Aligned vreset at the last pixel of frame 2: no discontinuity, lock held.
    push_line(b + 1 + 2 * FN + (VT - 1) * HT, VT - 1, 1'b0);
    push_frame(b + 1 + 3 * FN, 1'b0);
    expect_pin(b + 3 * FN, 6, 1);
    expect_pin(b + 3 * FN + 1, 6, 1);
    expect_pin(b + 3 * FN + 20, 6, 1);
    wait_cyc(b + 3 * FN - 1);
    vif.vreset = 1'b1;
    @(negedge clk);
    vif.vreset = 1'b0;
    wait_cyc(b + 4 * FN + 1);

    // Misaligned vreset at (10,1), then relock; an aligned vreset at the first wrap keeps the count.
    e  = b + 4 * FN + HT + 10;
    b2 = e + 1;
    e5 = b2 + FN - 1;
    expect_pin(e, 6, 1);
    expect_pin(e + 1, 6, 0);
    expect_pin(e + 1, 3, 10);
    expect_pin(e + 1, 4, 1);
    expect_pin(e + 1, 5, 0);
    push_frame(b2 + 1, 1'b0);
    push_frame(b2 + 1 + FN, 1'b0);
    expect_pin(b2 + 1 + 2 * FN - 2, 6, 0);
    expect_pin(b2 + 1 + 2 * FN - 1, 6, 1);
    wait_cyc(e);
    vif.vreset = 1'b1;
    @(negedge clk);
    vif.vreset = 1'b0;
    wait_cyc(e5);
    vif.vreset = 1'b1;
    @(negedge clk);
    vif.vreset = 1'b0;
    wait_cyc(b2 + 2 * FN + 1);

    // vreset held for three cycles at (5,1): origin repeats, count resumes at 1.
    e  = b2 + 2 * FN + HT + 5;
    b3 = e + 3;
    expect_pin(e, 6, 1);
    expect_pin(e + 1, 6, 0);
    expect_pin(e + 1, 3, 5);
    expect_pin(e + 1, 4, 1);
    push_origin(e + 2);
    push_origin(e + 3);
    push_line(b3 + 1, 0, 1'b0);
    push_line(b3 + 1 + HT, 1, 1'b0);
    wait_cyc(e);
    vif.vreset = 1'b1;
    repeat (3) @(negedge clk);
    vif.vreset = 1'b0;
    wait_cyc(b3 + 1 + 2 * HT);

    // Wide from reset: first line still normal, then wide lines; toggle back mid-line.
    reset = 1'b1;
    vif.wide = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b  = cyc;
    f0 = HT + (VT - 1) * HTW;
    push_line(b + 1, 0, 1'b0);
    for (int y = 1; y < VT; y++) push_line(b + 1 + HT + (y - 1) * HTW, y, 1'b1);
    push_frame(b + 1 + f0, 1'b1);
    c2 = b + 1 + f0 + FW;
    for (int y = 0; y < 3; y++) push_line(c2 + y * HTW, y, 1'b1);
    push_line(c2 + 3 * HTW, 3, 1'b0);
    push_line(c2 + 3 * HTW + HT, 4, 1'b0);
    expect_pin(c2 - 2, 6, 0);
    expect_pin(c2 - 1, 6, 1);
    expect_pin(c2 + 2 * HTW + 28, 6, 1);
    expect_pin(c2 + 2 * HTW + 29, 6, 0);
    wait_cyc(c2 - 1 + 2 * HTW + 10);
    vif.wide = 1'b0;
    wait_cyc(c2 + 3 * HTW + 2 * HT);

    // Asynchronous reset mid-line, then a clean restart from the origin.
    wait_cyc(c2 + 3 * HTW + 2 * HT + 9);
    @(posedge clk);
    #1;
    reset = 1'b1;
    e = cyc;
    push_reset_pins(e);
    push_reset_pins(e + 1);
    wait_cyc(e + 1);
    reset = 1'b0;
    b = cyc;
    push_line(b + 1, 0, 1'b0);
    expect_pin(b + 1, 6, 0);

    wait_cyc(last_c + 1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sbq.size());
    $fatal(1, "watchdog expired");
  end
endmodule
